decoder3_8_hold: RTL and testbench

Sequential 3-to-8 decoder, the consumer end of the 8:3 priority encoder path. It accepts a 3-bit index over a valid/ready handshake and drives the matching one-hot line with its own valid/ready handshake. After each output transfer it enforces a programmable idle gap. It also keeps a wrapping count of completed decodes for debug.

---
 rtl/decoder3_8_hold.sv | 109 ++++++++++
 tb/tb_decoder3_8_hold.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/decoder3_8_hold.sv
// Sequential 3-to-8 decoder with valid/ready on both sides, a programmable
// post-transfer idle gap and a wrapping count of completed decodes.
module decoder3_8_hold #(
    parameter int unsigned GAP   = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       in_idx,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] decode_count
);

    localparam int unsigned GAP_W = 4;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DRIVE    = 2'd1;
    localparam logic [1:0] GAP_WAIT = 2'd2;

    logic [1:0]       state,        state_nxt;
    logic [GAP_W-1:0] gap_cnt,      gap_nxt;
    logic [7:0]       onehot_nxt;
    logic             valid_nxt;
    logic             ready_nxt;
    logic             busy_nxt;
    logic [CNT_W-1:0] count_nxt;

    // State and every output are registered; next values come from below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            out_onehot   <= 8'h00;
            out_valid    <= 1'b0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
            decode_count <= '0;
        end else begin
            state        <= state_nxt;
            gap_cnt      <= gap_nxt;
            out_onehot   <= onehot_nxt;
            out_valid    <= valid_nxt;
            in_ready     <= ready_nxt;
            busy         <= busy_nxt;
            decode_count <= count_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        gap_nxt    = gap_cnt;
        onehot_nxt = out_onehot;
        valid_nxt  = out_valid;
        ready_nxt  = in_ready;
        busy_nxt   = busy;
        count_nxt  = decode_count;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    onehot_nxt = 8'b1 << in_idx;
                    valid_nxt  = 1'b1;
                    ready_nxt  = 1'b0;
                    busy_nxt   = 1'b1;
                    state_nxt  = DRIVE;
                end
            end
            DRIVE: begin
                if (out_valid && out_ready) begin
                    onehot_nxt = 8'h00;
                    valid_nxt  = 1'b0;
                    count_nxt  = decode_count + CNT_W'(1);
                    if (GAP > 0) begin
                        // Loaded with GAP-1 so GAP_WAIT lasts exactly GAP cycles.
                        gap_nxt   = GAP_W'(GAP - 1);
                        state_nxt = GAP_WAIT;
                    end else begin
                        ready_nxt = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            GAP_WAIT: begin
                if (gap_cnt == '0) begin
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                onehot_nxt = 8'h00;
                valid_nxt  = 1'b0;
                ready_nxt  = 1'b1;
                busy_nxt   = 1'b0;
                state_nxt  = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_decoder3_8_hold.sv
// Directed bench for decoder3_8_hold: reset, sweep, back-pressure, ignored
// input, counter wrap, and accept spacing for GAP=0 versus GAP=3.
module tb_decoder3_8_hold;

    logic       clk;
    logic       rst_n;
    logic [2:0] in_idx;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_onehot;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic [7:0] decode_count;

    // Side instances for the gap-spacing comparison.
    logic       g_valid;
    logic       g_oready;
    logic [2:0] g_idx;
    logic       rdy0, val0, busy0, rdy3, val3, busy3;
    logic [7:0] oh0, oh3, cnt0, cnt3;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int last0 = -1, last3 = -1, sp0 = 0, sp3 = 0, n0 = 0, n3 = 0;

    decoder3_8_hold #(.GAP(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_idx(in_idx), .in_valid(in_valid),
        .in_ready(in_ready), .out_onehot(out_onehot), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .decode_count(decode_count)
    );

    decoder3_8_hold #(.GAP(0), .CNT_W(8)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .in_idx(g_idx), .in_valid(g_valid),
        .in_ready(rdy0), .out_onehot(oh0), .out_valid(val0),
        .out_ready(g_oready), .busy(busy0), .decode_count(cnt0)
    );

    decoder3_8_hold #(.GAP(3), .CNT_W(8)) dut_g3 (
        .clk(clk), .rst_n(rst_n), .in_idx(g_idx), .in_valid(g_valid),
        .in_ready(rdy3), .out_onehot(oh3), .out_valid(val3),
        .out_ready(g_oready), .busy(busy3), .decode_count(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record accept spacing of the side instances.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && g_valid && rdy0) begin
            if (last0 >= 0) sp0 = cyc - last0;
            last0 = cyc;
            n0 = n0 + 1;
        end
        if (rst_n && g_valid && rdy3) begin
            if (last3 >= 0) sp3 = cyc - last3;
            last3 = cyc;
            n3 = n3 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_idx    = 3'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        g_valid   = 1'b0;
        g_oready  = 1'b1;
        g_idx     = 3'd2;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_onehot", 32'(out_onehot), 32'h00);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(decode_count), 32'd0);

        // Idle with no valid stays idle
        step();
        step();
        check("idle_onehot", 32'(out_onehot), 32'h00);
        check("idle_busy", 32'(busy), 32'd0);

        // Sweep with in_valid held: accepts every 4 cycles at GAP=2
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("sweep_onehot", 32'(out_onehot), 32'h1 << i);
            check("sweep_valid", 32'(out_valid), 32'd1);
            check("sweep_ready", 32'(in_ready), 32'd0);
            check("sweep_busy", 32'(busy), 32'd1);
            in_idx = 3'(i + 1);
            step();
            check("sweep_xfer_onehot", 32'(out_onehot), 32'h00);
            check("sweep_xfer_valid", 32'(out_valid), 32'd0);
            check("sweep_count", 32'(decode_count), 32'(i + 1));
            step();
            check("sweep_gap_ready", 32'(in_ready), 32'd0);
            check("sweep_gap_onehot", 32'(out_onehot), 32'h00);
            step();
            check("sweep_idle_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        check("sweep_total", 32'(decode_count), 32'd8);

        // Back-pressure: idx 3 held for 6 cycles, one increment
        out_ready = 1'b0;
        in_idx    = 3'd3;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            check("bp_onehot", 32'(out_onehot), 32'h08);
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_count", 32'(decode_count), 32'd8);
            step();
        end
        out_ready = 1'b1;
        check("bp_onehot_last", 32'(out_onehot), 32'h08);
        step();
        check("bp_count_after", 32'(decode_count), 32'd9);
        check("bp_valid_after", 32'(out_valid), 32'd0);
        step();
        step();
        check("bp_idle_ready", 32'(in_ready), 32'd1);

        // in_idx change during DRIVE is ignored
        out_ready = 1'b0;
        in_idx    = 3'd6;
        in_valid  = 1'b1;
        step();
        in_idx = 3'd1;
        step();
        check("ign_onehot", 32'(out_onehot), 32'h40);
        out_ready = 1'b1;
        check("ign_onehot_2", 32'(out_onehot), 32'h40);
        step();
        in_valid = 1'b0;
        check("ign_count", 32'(decode_count), 32'd10);
        check("ign_cleared", 32'(out_onehot), 32'h00);
        step();
        step();

        // Wrap: 257 transfers in total since reset
        in_valid = 1'b1;
        in_idx   = 3'd7;
        for (int n = 0; n < 246; n++) begin
            step(); step(); step(); step();
        end
        check("wrap_zero", 32'(decode_count), 32'd0);
        step(); step(); step(); step();
        in_valid = 1'b0;
        check("wrap_one", 32'(decode_count), 32'd1);

        // Asynchronous reset mid-DRIVE discards idx 5
        out_ready = 1'b0;
        in_idx    = 3'd5;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        check("arst_pre_onehot", 32'(out_onehot), 32'h20);
        #2 rst_n = 1'b0;
        #1;
        check("arst_onehot", 32'(out_onehot), 32'h00);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_count", 32'(decode_count), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("arst_no_output", 32'(out_valid), 32'd0);

        // GAP=0 vs GAP=3 with in_valid held high for 20 cycles
        g_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (val3 === 1'b0) check("g3_onehot_idle", 32'(oh3), 32'h00);
        end
        g_valid = 1'b0;
        check("g0_spacing", 32'(sp0), 32'd2);
        check("g3_spacing", 32'(sp3), 32'd5);
        check("g0_accepts", 32'(n0), 32'd10);
        check("g3_accepts", 32'(n3), 32'd4);
        check("g0_count", 32'(cnt0), 32'd10);
        check("g3_count", 32'(cnt3), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
